// File: rtl/dispatcher.sv
// rtl/dispatcher.sv - dispatches the FIFO head entry to the lowest-index idle counter
// Each dispatch is followed by one cooldown cycle so the FIFO and counters can react.
module dispatcher (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       empty,
    input  logic [3:0] qn,
    input  logic [3:0] qt,
    input  logic [2:0] busy,
    output logic       re,
    output logic       ld1,
    output logic       ld2,
    output logic       ld3,
    output logic [3:0] dn1,
    output logic [3:0] dn2,
    output logic [3:0] dn3,
    output logic [3:0] dt1,
    output logic [3:0] dt2,
    output logic [3:0] dt3
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            re_q, re_d;
    logic [2:0]      ld_q, ld_d;
    logic [2:0][3:0] dn_q, dn_d;
    logic [2:0][3:0] dt_q, dt_d;

    always_comb begin
        state_d = state_q;
        re_d    = 1'b0;
        ld_d    = 3'b000;
        dn_d    = dn_q;
        dt_d    = dt_q;
        case (state_q)
            IDLE: begin
                if (!empty && busy != 3'b111) begin
                    re_d    = 1'b1;
                    state_d = HOLD;
                    // Fixed priority: lowest-numbered free counter wins.
                    if (!busy[0]) begin
                        ld_d    = 3'b001;
                        dn_d[0] = qn;
                        dt_d[0] = qt;
                    end else if (!busy[1]) begin
                        ld_d    = 3'b010;
                        dn_d[1] = qn;
                        dt_d[1] = qt;
                    end else begin
                        ld_d    = 3'b100;
                        dn_d[2] = qn;
                        dt_d[2] = qt;
                    end
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // rst_n is the legacy active-high asynchronous reset despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            re_q    <= 1'b0;
            ld_q    <= 3'b000;
            dn_q    <= '0;
            dt_q    <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            ld_q    <= ld_d;
            dn_q    <= dn_d;
            dt_q    <= dt_d;
        end
    end

    assign re  = re_q;
    assign ld1 = ld_q[0];
    assign ld2 = ld_q[1];
    assign ld3 = ld_q[2];
    assign dn1 = dn_q[0];
    assign dn2 = dn_q[1];
    assign dn3 = dn_q[2];
    assign dt1 = dt_q[0];
    assign dt2 = dt_q[1];
    assign dt3 = dt_q[2];

endmodule

// File: tb/tb_dispatcher.sv
// tb/tb_dispatcher.sv - directed and randomized checks of dispatcher against a behavioural model
module tb_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       empty;
    logic [3:0] qn, qt;
    logic [2:0] busy;
    logic       re, ld1, ld2, ld3;
    logic [3:0] dn1, dn2, dn3, dt1, dt2, dt3;

    int tests = 0;
    int fails = 0;

    // Model: last-dispatch memory per counter plus a "just dispatched" cooldown flag.
    logic       m_re;
    logic [2:0] m_ld;
    logic [3:0] m_dn [3];
    logic [3:0] m_dt [3];
    bit         m_cool;

    dispatcher dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .qn(qn), .qt(qt), .busy(busy),
        .re(re), .ld1(ld1), .ld2(ld2), .ld3(ld3),
        .dn1(dn1), .dn2(dn2), .dn3(dn3), .dt1(dt1), .dt2(dt2), .dt3(dt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_re   = 1'b0;
        m_ld   = 3'b000;
        m_cool = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_dn[k] = 4'd0;
            m_dt[k] = 4'd0;
        end
    endtask

    task automatic model_edge();
        int sel;
        m_re = 1'b0;
        m_ld = 3'b000;
        if (rst_n) begin
            model_reset();
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (!empty) begin
            sel = -1;
            for (int k = 2; k >= 0; k--)
                if (busy[k] == 1'b0) sel = k;
            if (sel >= 0) begin
                m_re      = 1'b1;
                m_ld[sel] = 1'b1;
                m_dn[sel] = qn;
                m_dt[sel] = qt;
                m_cool    = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".re"}, {3'b0, re}, {3'b0, m_re});
        chk({tag, ".ld"}, {1'b0, ld3, ld2, ld1}, {1'b0, m_ld});
        chk({tag, ".dn1"}, dn1, m_dn[0]);
        chk({tag, ".dn2"}, dn2, m_dn[1]);
        chk({tag, ".dn3"}, dn3, m_dn[2]);
        chk({tag, ".dt1"}, dt1, m_dt[0]);
        chk({tag, ".dt2"}, dt2, m_dt[1]);
        chk({tag, ".dt3"}, dt3, m_dt[2]);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic e, input logic [3:0] n, input logic [3:0] t, input logic [2:0] b);
        empty = e;
        qn    = n;
        qt    = t;
        busy  = b;
    endtask

    int pulses;

    initial begin
        rst_n = 1'b1;
        drive(1'b1, 4'd0, 4'd0, 3'b000);
        model_reset();
        #1;
        check_all("reset_async");
        tick("reset0");
        tick("reset1");
        chk("reset_re_const", {3'b0, re}, 4'd0);

        rst_n = 1'b0;
        drive(1'b0, 4'd10, 4'd3, 3'b111);
        tick("allbusy0");
        tick("allbusy1");
        chk("allbusy_dn1_const", dn1, 4'd0);

        drive(1'b0, 4'd11, 4'd2, 3'b110);
        pulses = 0;
        tick("c1_dispatch");
        chk("c1_ld_const", {1'b0, ld3, ld2, ld1}, 4'b0001);
        pulses += int'(re);
        tick("c1_hold");
        pulses += int'(re);
        drive(1'b1, 4'd11, 4'd2, 3'b110);
        tick("c1_empty");
        pulses += int'(re);
        chk("c1_single_pulse", pulses[3:0], 4'd1);
        chk("c1_dn1_const", dn1, 4'd11);
        chk("c1_dt1_const", dt1, 4'd2);

        drive(1'b0, 4'd12, 4'd4, 3'b101);
        tick("c2_dispatch");
        chk("c2_ld_const", {1'b0, ld3, ld2, ld1}, 4'b0010);
        drive(1'b1, 4'd12, 4'd4, 3'b101);
        tick("c2_hold");
        chk("c2_dn2_const", dn2, 4'd12);
        chk("c2_dn1_kept", dn1, 4'd11);

        drive(1'b0, 4'd13, 4'd1, 3'b011);
        tick("c3_dispatch");
        chk("c3_ld_const", {1'b0, ld3, ld2, ld1}, 4'b0100);
        drive(1'b1, 4'd13, 4'd1, 3'b011);
        tick("c3_hold");
        chk("c3_dt3_const", dt3, 4'd1);

        drive(1'b0, 4'd5, 4'd7, 3'b000);
        tick("prio_dispatch");
        chk("prio_ld_const", {1'b0, ld3, ld2, ld1}, 4'b0001);
        chk("prio_dn1_const", dn1, 4'd5);
        tick("prio_hold");

        // Continuous demand: re must alternate 1,0,1,0...
        drive(1'b0, 4'd0, 4'd0, 3'b000);
        for (int i = 0; i < 6; i++) begin
            qn = 4'(i);
            tick("b2b");
            chk("b2b_alternate", {3'b0, re}, {3'b0, ~i[0]});
        end

        drive(1'b1, 4'd0, 4'd0, 3'b000);
        tick("pre_midreset");
        drive(1'b0, 4'd9, 4'd9, 3'b011);
        tick("midreset_dispatch");
        chk("midreset_ld3_const", {3'b0, ld3}, 4'd1);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_all("midreset_async");
        tick("midreset_hold");
        rst_n = 1'b0;
        tick("after_reset_first");
        chk("after_reset_latency", {3'b0, re}, 4'd1);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), 3'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b1;
                #1;
                model_reset();
                check_all("rand_async_reset");
            end else begin
                rst_n = 1'b0;
            end
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high.
REQ-004 empty  input  1  upstream FIFO empty flag; 0 means qn/qt hold a valid head entry.
REQ-005 qn  input  4  customer number at the FIFO head.
REQ-006 qt  input  4  service time at the FIFO head.
REQ-007 busy  input  3  counter busy flags; bit0 = counter 1, bit1 = counter 2, bit2 = counter 3; 1 means busy.
REQ-008 re  output  1  FIFO read strobe; one-cycle pulse that pops the head entry.
REQ-009 ld1 / ld2 / ld3  output  1 each  load strobe to counter 1/2/3; one-cycle pulse.
REQ-010 dn1 / dn2 / dn3  output  4 each  customer number last dispatched to counter 1/2/3.
REQ-011 dt1 / dt2 / dt3  output  4 each  service time last dispatched to counter 1/2/3.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The FSM SHALL have two states:
  - IDLE: waiting for dispatch.
  - HOLD: one-cycle cooldown after a dispatch.
REQ-014 In IDLE, a rising edge with empty=0 and at least one busy bit at 0 SHALL dispatch.
REQ-015 A dispatch SHALL, on the same edge:
  - set re=1;
  - set exactly one ld of the selected counter to 1;
  - load dn/dt of that counter from qn/qt;
  - move the FSM to HOLD.
REQ-016 Counter selection SHALL be fixed priority, lowest index first: counter 1 if busy[0]=0, else counter 2 if busy[1]=0, else counter 3.
REQ-017 In IDLE, if empty=1 or busy=3'b111, there SHALL be no dispatch: re and all ld stay 0 and the FSM stays in IDLE.
REQ-018 re and ld SHALL be high for exactly one clock per dispatch; they return to 0 on the next edge.
REQ-019 HOLD SHALL last exactly one cycle, then return to IDLE unconditionally; empty and busy are ignored in HOLD.
  - Purpose: gives the FIFO time to advance and the counter time to raise busy.
  - Result: at most one dispatch every two cycles.
REQ-020 Latency: the dispatch appears on the first rising edge at which the IDLE conditions are sampled true.
REQ-021 dnK and dtK SHALL update only on counter K's dispatch edge and otherwise hold their value.
  - Non-selected counters' dn/dt SHALL never change.
REQ-022 qt=0 and qn=0 are valid data and SHALL be dispatched like any other value; there is no range check.
REQ-023 If busy changes in the same cycle as a dispatch, the busy value sampled at that edge governs the selection.

Reset
REQ-024 While rst_n=1, the block SHALL be in reset, asynchronously and independent of clk:
  - FSM = IDLE;
  - re = ld1 = ld2 = ld3 = 0;
  - dn1..dn3 = dt1..dt3 = 0.
REQ-025 Reset asserted during HOLD or during a dispatch pulse SHALL immediately clear the pulses and return the FSM to IDLE.
REQ-026 After reset deasserts, the first dispatch SHALL occur at the first qualifying edge; no extra idle cycles are inserted.

Verification
REQ-027 Reset and no-dispatch cases, each held for 2 cycles:
  - rst_n=1 -> all outputs 0.
  - empty=0, qn=10, qt=3, busy=111 -> re and ld1..3 stay 0; dn/dt unchanged (0).
REQ-028 Dispatch to counter 1:
  - Stimulus: empty=0, qn=11, qt=2, busy=110, held 2 cycles, then empty=1.
  - Response: a single 1-cycle re/ld1 pulse; dn1=11, dt1=2; ld2/ld3 stay 0; no second pulse.
REQ-029 Dispatch to counter 2:
  - Stimulus: qn=12, qt=4, busy=101.
  - Response: a single re/ld2 pulse; dn2=12, dt2=4; dn1=11 and dt1=2 retained.
REQ-030 Dispatch to counter 3:
  - Stimulus: qn=13, qt=1, busy=011.
  - Response: a single re/ld3 pulse; dn3=13, dt3=1.
REQ-031 Priority: busy=000, qn=5, qt=7 -> ld1 only; dn1=5, dt1=7.
REQ-032 Back-to-back: empty=0 held continuously with busy=000 -> re pulses on alternate cycles only (HOLD spacing).
REQ-033 Reset mid-operation: rst_n=1 asserted during the HOLD cycle -> re and ld clear immediately; all dn/dt = 0.
